// File: rtl/sha256_compress.sv
// SHA-256 compression core: consumes one schedule word per accepted cycle,
// runs 64 rounds on a..h and folds the result into the chaining state H.
`timescale 1ns/1ps

module sha256_compress #(
    parameter int DATA_WIDTH = 32,
    parameter int ROUNDS     = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_in,
    input  logic                    first_block_in,
    input  logic                    w_valid_in,
    input  logic [DATA_WIDTH-1:0]   w_in,
    output logic [5:0]              round_count_out,
    output logic                    w_ready_out,
    output logic                    busy_out,
    output logic [8*DATA_WIDTH-1:0] digest_out,
    output logic                    digest_valid_out
);

    typedef enum logic [2:0] {IDLE, LOAD, ROUND, UPDATE, DONE} state_t;

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    state_t      state_q, state_d;
    logic        firstBlock_q, firstBlock_d;
    logic [5:0]  round_q, round_d;
    logic [31:0] work_q [8];
    logic [31:0] work_d [8];
    logic [31:0] hash_q [8];
    logic [31:0] hash_d [8];
    logic [31:0] t1, t2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            firstBlock_q <= 1'b0;
            round_q      <= '0;
            for (int i = 0; i < 8; i++) begin
                work_q[i] <= '0;
                hash_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            firstBlock_q <= firstBlock_d;
            round_q      <= round_d;
            work_q       <= work_d;
            hash_q       <= hash_d;
        end
    end

    // Round datapath is evaluated every cycle but only committed on an accepted word.
    always_comb begin
        state_d      = state_q;
        firstBlock_d = firstBlock_q;
        round_d      = round_q;
        work_d       = work_q;
        hash_d       = hash_q;

        t1 = work_q[7]
           + (rotr(work_q[4], 6) ^ rotr(work_q[4], 11) ^ rotr(work_q[4], 25))
           + ((work_q[4] & work_q[5]) ^ (~work_q[4] & work_q[6]))
           + K[round_q] + w_in;
        t2 = (rotr(work_q[0], 2) ^ rotr(work_q[0], 13) ^ rotr(work_q[0], 22))
           + ((work_q[0] & work_q[1]) ^ (work_q[0] & work_q[2]) ^ (work_q[1] & work_q[2]));

        case (state_q)
            IDLE: begin
                if (start_in) begin
                    state_d      = LOAD;
                    firstBlock_d = first_block_in;
                end
            end
            LOAD: begin
                if (firstBlock_q) begin
                    hash_d = IV;
                    work_d = IV;
                end else begin
                    work_d = hash_q;
                end
                round_d = '0;
                state_d = ROUND;
            end
            ROUND: begin
                if (w_valid_in) begin
                    work_d[7] = work_q[6];
                    work_d[6] = work_q[5];
                    work_d[5] = work_q[4];
                    work_d[4] = work_q[3] + t1;
                    work_d[3] = work_q[2];
                    work_d[2] = work_q[1];
                    work_d[1] = work_q[0];
                    work_d[0] = t1 + t2;
                    round_d   = round_q + 6'd1;
                    if (round_q == 6'(ROUNDS - 1)) begin
                        state_d = UPDATE;
                    end
                end
            end
            UPDATE: begin
                for (int i = 0; i < 8; i++) begin
                    hash_d[i] = hash_q[i] + work_q[i];
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign round_count_out  = round_q;
    assign w_ready_out      = (state_q == ROUND);
    assign busy_out         = (state_q != IDLE);
    assign digest_valid_out = (state_q == DONE);
    assign digest_out       = {hash_q[0], hash_q[1], hash_q[2], hash_q[3],
                               hash_q[4], hash_q[5], hash_q[6], hash_q[7]};

endmodule
